// File: rtl/rr_mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: channel count,
// FSM state encoding and default datapath widths.
package rr_mux_sched_pkg;

  localparam int NUM_CH     = 4;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SWIDTH = 2;

  // The output register is either empty (IDLE) or holding a transfer (HOLD).
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/mux_case.sv
// Plain 4:1 case-statement multiplexer used for channel data selection.
module mux_case #(
  parameter int width  = 4,
  parameter int swidth = 2
) (
  input  logic [width-1:0]  i0,
  input  logic [width-1:0]  i1,
  input  logic [width-1:0]  i2,
  input  logic [width-1:0]  i3,
  input  logic [swidth-1:0] sel,
  output logic [width-1:0]  y
);

  // Route the selected channel to the output.
  always_comb begin
    y = i0;
    case (sel[1:0])
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler for four request channels feeding one registered
// output slot. The arbiter picks a winner starting after the last granted
// channel; the FSM loads the output register whenever it is empty or being
// drained in the same cycle, giving one transfer per cycle back-to-back.
module rr_mux_sched
  import rr_mux_sched_pkg::*;
#(
  parameter int width  = DEF_WIDTH,
  parameter int swidth = DEF_SWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [width-1:0]  i0,
  input  logic [width-1:0]  i1,
  input  logic [width-1:0]  i2,
  input  logic [width-1:0]  i3,
  input  logic              out_ready,
  output logic [3:0]        gnt,
  output logic [swidth-1:0] sel,
  output logic [width-1:0]  out_data,
  output logic              out_valid,
  output logic [swidth-1:0] out_ch
);

  logic [0:0]        state_q, state_d;
  logic [swidth-1:0] last_q, last_d;
  logic [width-1:0]  out_data_q, out_data_d;
  logic [swidth-1:0] out_ch_q, out_ch_d;

  logic              any_req;
  logic              found;
  logic              load;
  logic [1:0]        idx;
  logic [swidth-1:0] winner;
  logic [width-1:0]  mux_y;

  assign any_req = |req;

  // Round-robin search: scan channels last+1, last+2, ... and take the first requester.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_q[1:0] + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = swidth'(idx);
      end
    end
  end

  // A load happens when a requester exists and the slot is empty or draining; reset blocks it.
  always_comb begin
    load = !rst && found && ((state_q == ST_IDLE) || out_ready);
    sel  = load ? winner : last_q;
    gnt  = load ? (4'b0001 << winner) : 4'b0000;
  end

  mux_case #(
    .width  (width),
    .swidth (swidth)
  ) u_mux (
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .sel (sel),
    .y   (mux_y)
  );

  // Next-state logic: load the winner, drain to IDLE, or hold everything stable.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    if (load) begin
      state_d    = ST_HOLD;
      last_d     = winner;
      out_data_d = mux_y;
      out_ch_d   = winner;
    end else if ((state_q == ST_HOLD) && out_ready && !any_req) begin
      state_d = ST_IDLE;
    end
  end

  // State registers; reset empties the slot and makes channel 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= swidth'(NUM_CH - 1);
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: doc/rr_mux_sched.md
RR_MUX_SCHED -- requirements
Module: rr_mux_sched

Interface
REQ-001 Parameter: width, default 4, data width per channel.
REQ-002 Parameter: swidth, default 2, channel-select width (4 channels).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-channel request; req[n] set means channel n holds data.
REQ-006 i0..i3  input  width each  channel data, valid while the matching req bit is set.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 gnt  output  4  one-hot, one-cycle pulse; channel n data consumed.
REQ-009 sel  output  swidth  channel currently selected (drives the 4:1 mux select).
REQ-010 out_data  output  width  registered selected data.
REQ-011 out_valid  output  1  out_data/out_ch hold a transfer.
REQ-012 out_ch  output  swidth  channel index of out_data.

Function
REQ-013 Two-state FSM SHALL be used: IDLE (output register empty) and HOLD (out_valid=1).
REQ-014 Arbitration SHALL be round-robin: search starts at last+1 (mod 4), first set req bit wins; last = most recently granted channel.
REQ-015 "Load" SHALL mean: out_data <= mux(winner), out_ch <= winner, last <= winner, gnt[winner]=1 for that cycle, out_valid=1 next cycle.
REQ-016 IDLE with any req set SHALL perform a load and go to HOLD; with req=0 it stays in IDLE, gnt=0.
REQ-017 HOLD with out_ready=0 SHALL keep out_data, out_ch, out_valid stable and gnt=0, regardless of req changes.
REQ-018 HOLD with out_ready=1 and any req set SHALL load the next winner in the same cycle and stay in HOLD (back-to-back, one transfer per cycle).
REQ-019 HOLD with out_ready=1 and req=0 SHALL clear out_valid and go to IDLE.
REQ-020 Latency: req rising in IDLE at edge k -> out_valid=1 after edge k+1; gnt pulses in the cycle between.
REQ-021 sel SHALL combinationally equal the arbitration winner whenever a load occurs, else equal last.
REQ-022 gnt SHALL be combinational, at most one bit set, and never set in a cycle without a load.
REQ-023 A channel that keeps req high SHALL be granted at most once per round while any other channel requests (no starvation).
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, out_valid=0, out_data=0, out_ch=0, last=3 (channel 0 first priority).
REQ-026 gnt SHALL be 0 while rst=1; reset mid-transfer SHALL discard the held data without a gnt pulse.
REQ-027 rst SHALL take priority over all other inputs.

Structure
REQ-028 Shared package SHALL hold: channel count (4), FSM state encoding (IDLE, HOLD), default width/swidth.
REQ-029 Datapath selection SHALL instantiate the team's existing 4:1 case mux (mux_case) driven by sel; arbiter and FSM stay in rr_mux_sched.

Verification
REQ-030 Reset: rst=1 for 2 cycles with req=4'hF -> out_valid=0, gnt=0, out_data=0; first grant after release is channel 0.
REQ-031 Single request: req=4'b0100, i2=4'hA, out_ready=1 -> gnt=4'b0100 one cycle, next cycle out_data=4'hA, out_ch=2, out_valid=1.
REQ-032 Round-robin: req=4'hF held, out_ready=1, i0..i3=1,2,3,4 -> out_data sequence 1,2,3,4,1 on consecutive cycles, gnt 0001,0010,0100,1000,0001.
REQ-033 Backpressure: out_ready=0 for 3 cycles while HOLD with out_data=4'h5 -> out_data stays 4'h5, gnt=0; out_ready=1 -> next channel loaded same cycle.
REQ-034 Drain: single transfer, req drops to 0, out_ready=1 -> out_valid=0 next cycle, FSM in IDLE.
REQ-035 Reset mid-operation: rst=1 during HOLD with out_ready=0 -> out_valid=0 next cycle, no gnt, next grant starts at channel 0.
